// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: HUB75 row-pair scan driver with binary-code-modulated colour planes.
// Optional BRIGHTNESS_EN adds an 8-bit brightness input that scales each plane's on-time.
module hub75_bcm_scanner #(
   parameter int COLS       = 64,
   parameter int SCAN_ROWS  = 16,
   parameter int COLOR_BITS = 4,
   parameter int CLK_DIV    = 2,
   parameter int BASE_ON    = 64,
   localparam int ROW_BITS  = $clog2(SCAN_ROWS),
   localparam int COL_BITS  = $clog2(COLS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
`ifdef BRIGHTNESS_EN
   input  logic [7:0]                   brightness,
`endif
   output logic                         fb_rd,
   output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
   input  logic [3*COLOR_BITS-1:0]      fb_top,
   input  logic [3*COLOR_BITS-1:0]      fb_bot,
   output logic [ROW_BITS-1:0]          ADDR,
   output logic                         R0,
   output logic                         G0,
   output logic                         B0,
   output logic                         R1,
   output logic                         G1,
   output logic                         B1,
   output logic                         CLK_OUT,
   output logic                         LAT,
   output logic                         OE,
   output logic                         frame_done
);
   localparam int PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam int OW = $clog2((BASE_ON << (COLOR_BITS - 1)) + 1);
   localparam int IW = $clog2(3 * COLOR_BITS);

   typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, BLANK, LATCH, ON} state_t;
   state_t state, state_nx;

   logic [ROW_BITS-1:0]     row;
   logic [PW-1:0]           plane;
   logic [COL_BITS-1:0]     col, rd_col;
   logic [DW-1:0]           div;
   logic [OW-1:0]           on_cnt, on_full, on_len;
   logic                    on_dark, rd_q;
   logic [3*COLOR_BITS-1:0] top_q, bot_q, top_px, bot_px;
   logic [IW-1:0]           ir, ig, ib;
   logic                    slot_start, slot_end, last_col, last_plane, last_row, frame_end, on_end;

   assign slot_start = state == SHIFT && div == '0;
   assign slot_end   = state == SHIFT && div == DW'(CLK_DIV - 1);
   assign last_col   = col == COL_BITS'(COLS - 1);
   assign last_plane = plane == PW'(COLOR_BITS - 1);
   assign last_row   = row == ROW_BITS'(SCAN_ROWS - 1);
   assign frame_end  = last_plane && last_row;
   assign on_end     = on_cnt == '0;
   assign on_full    = OW'(BASE_ON) << plane;

`ifdef BRIGHTNESS_EN
   logic [OW+8:0] on_prod;
   assign on_prod = (OW+9)'(on_full) * (OW+9)'(brightness + 9'd1);
   assign on_len  = OW'(on_prod >> 8);
`else
   assign on_len  = on_full;
`endif

   // The first slot's pixel arrives straight from the RAM; later slots use the held copy,
   // so the RAM only has to present data for the single cycle after each read.
   assign top_px = rd_q ? fb_top : top_q;
   assign bot_px = rd_q ? fb_bot : bot_q;
   assign ib     = IW'(plane);
   assign ig     = IW'(COLOR_BITS) + IW'(plane);
   assign ir     = IW'(2 * COLOR_BITS) + IW'(plane);

   assign rd_col  = (state == SHIFT) ? col + 1'b1 : '0;
   assign fb_addr = {row, rd_col};
   assign fb_rd   = state == PREFETCH || (slot_start && !last_col);
   assign CLK_OUT = state == SHIFT && div >= DW'(CLK_DIV / 2);
   assign LAT     = state == LATCH;
   assign OE      = !(state == ON && !on_dark);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = en ? PREFETCH : IDLE;
         PREFETCH: state_nx = SHIFT;
         SHIFT:    state_nx = (slot_end && last_col) ? BLANK : SHIFT;
         BLANK:    state_nx = LATCH;
         LATCH:    state_nx = ON;
         ON:       state_nx = !on_end ? ON : (frame_end && !en) ? IDLE : PREFETCH;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         row        <= '0;
         plane      <= '0;
         col        <= '0;
         div        <= '0;
         on_cnt     <= '0;
         on_dark    <= 1'b0;
         rd_q       <= 1'b0;
         top_q      <= '0;
         bot_q      <= '0;
         ADDR       <= '0;
         {R0, G0, B0, R1, G1, B1} <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         rd_q       <= fb_rd;
         frame_done <= 1'b0;
         if (rd_q) begin
            top_q <= fb_top;
            bot_q <= fb_bot;
         end
         if (state == IDLE) begin
            row   <= '0;
            plane <= '0;
         end
         if (state == PREFETCH) begin
            col <= '0;
            div <= '0;
         end
         if (state == SHIFT) begin
            div <= slot_end ? '0 : div + 1'b1;
            if (slot_end) col <= col + 1'b1;
         end
         if (slot_start)
            {R0, G0, B0, R1, G1, B1} <= {top_px[ir], top_px[ig], top_px[ib], bot_px[ir], bot_px[ig], bot_px[ib]};
         if (state == BLANK) ADDR <= row;
         // A zero-length plane still spends one ON cycle, but dark.
         if (state == LATCH) begin
            on_cnt  <= (on_len == '0) ? '0 : on_len - 1'b1;
            on_dark <= on_len == '0;
         end
         if (state == ON) begin
            on_cnt <= on_cnt - 1'b1;
            if (on_end) begin
               plane      <= last_plane ? '0 : plane + 1'b1;
               frame_done <= frame_end;
               if (last_plane) row <= last_row ? '0 : row + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb_hub75_bcm_scanner: scoreboard bench; a frame-level model queues expected reads, pixels,
// latches and on-times, and a pin monitor pops and compares them as the panel signals appear.
module tb_hub75_bcm_scanner;
   localparam int COLS = 4, SCAN_ROWS = 2, COLOR_BITS = 2, CLK_DIV = 2, BASE_ON = 4;
   localparam int RB = 1, AW = 3, CW = 3 * COLOR_BITS;

   logic          clk = 1'b0, rst = 1'b0, en = 1'b0;
   logic          fb_rd;
   logic [AW-1:0] fb_addr;
   logic [CW-1:0] fb_top = '0, fb_bot = '0;
   logic [RB-1:0] ADDR;
   logic          R0, G0, B0, R1, G1, B1, CLK_OUT, LAT, OE, frame_done;
`ifdef BRIGHTNESS_EN
   logic [7:0]    brightness = 8'd255;
`endif

   logic [CW-1:0] mem_top [COLS*SCAN_ROWS];
   logic [CW-1:0] mem_bot [COLS*SCAN_ROWS];
   int checks = 0, errors = 0, cyc = 0, br = 255;
   bit mon_on = 1'b0;
   int exp_addr_q[$], exp_pix_q[$], exp_row_q[$], exp_on_q[$];

   hub75_bcm_scanner #(.COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .COLOR_BITS(COLOR_BITS),
                       .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON)) dut (
      .clk(clk), .rst(rst), .en(en),
`ifdef BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_top(fb_top), .fb_bot(fb_bot), .ADDR(ADDR),
      .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
      .CLK_OUT(CLK_OUT), .LAT(LAT), .OE(OE), .frame_done(frame_done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge clk) if (fb_rd) begin
      fb_top <= mem_top[fb_addr];
      fb_bot <= mem_bot[fb_addr];
   end

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int on_len(int p);
      return ((BASE_ON << p) * (br + 1)) >> 8;
   endfunction

   function automatic int bitof(logic [CW-1:0] v, int i);
      return (int'(v) >> i) & 1;
   endfunction

   function automatic int frame_cycles();
      int n = 0;
      for (int p = 0; p < COLOR_BITS; p++)
         n += 3 + COLS * CLK_DIV + ((on_len(p) > 0) ? on_len(p) : 1);
      return n * SCAN_ROWS;
   endfunction

   task automatic push_frame();
      for (int r = 0; r < SCAN_ROWS; r++)
         for (int p = 0; p < COLOR_BITS; p++) begin
            for (int c = 0; c < COLS; c++) begin
               int a = r * COLS + c;
               exp_addr_q.push_back(a);
               exp_pix_q.push_back((bitof(mem_top[a], 2*COLOR_BITS+p) << 5) | (bitof(mem_top[a], COLOR_BITS+p) << 4) |
                                   (bitof(mem_top[a], p) << 3) | (bitof(mem_bot[a], 2*COLOR_BITS+p) << 2) |
                                   (bitof(mem_bot[a], COLOR_BITS+p) << 1) | bitof(mem_bot[a], p));
            end
            exp_row_q.push_back(r);
            if (on_len(p) > 0) exp_on_q.push_back(on_len(p));
         end
   endtask

   logic          clk_p = 1'b0, lat_p = 1'b0, oe_p = 1'b1;
   logic [RB-1:0] addr_p = '0;
   int run = 0, shifts = 0, e;
   always @(negedge clk) begin
      if (mon_on) begin
         if (fb_rd) begin
            e = exp_addr_q.size() ? exp_addr_q.pop_front() : -1;
            check("fb_addr", int'(fb_addr), e);
         end
         if (CLK_OUT && !clk_p) begin
            e = exp_pix_q.size() ? exp_pix_q.pop_front() : -1;
            check("pixel {R0,G0,B0,R1,G1,B1}", int'({R0, G0, B0, R1, G1, B1}), e);
            shifts++;
         end
         if (LAT && !lat_p) begin
            e = exp_row_q.size() ? exp_row_q.pop_front() : -1;
            check("ADDR at latch", int'(ADDR), e);
            check("shifts per latch", shifts, COLS);
            shifts = 0;
         end
         if (!OE) run++;
         else if (run > 0) begin
            e = exp_on_q.size() ? exp_on_q.pop_front() : -1;
            check("OE low cycles", run, e);
            run = 0;
         end
         if (LAT) check("OE during LAT", int'(OE), 1);
         if (ADDR != addr_p) check("OE while ADDR changes", int'(OE && oe_p), 1);
      end else begin
         run = 0;
         shifts = 0;
      end
      clk_p = CLK_OUT; lat_p = LAT; oe_p = OE; addr_p = ADDR;
   end

   task automatic wait_done(output int t);
      t = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (frame_done) begin
            t = cyc;
            return;
         end
      end
      check("frame_done timeout", 0, 1);
   endtask

   task automatic drained();
      repeat (5) @(negedge clk);
      check("leftover expectations", exp_addr_q.size() + exp_pix_q.size() + exp_row_q.size() + exp_on_q.size(), 0);
      check("idle OE", int'(OE), 1);
      check("idle fb_rd", int'(fb_rd), 0);
   endtask

   task automatic run_frame();
      int t;
      push_frame();
      @(posedge clk) #1 en = 1'b1;
      @(posedge clk) #1 en = 1'b0;
      wait_done(t);
      drained();
   endtask

   task automatic set_br(int v);
      br = v;
`ifdef BRIGHTNESS_EN
      brightness = 8'(v);
`endif
   endtask

   task automatic fill_random();
      for (int a = 0; a < COLS*SCAN_ROWS; a++) begin
         mem_top[a] = CW'($urandom_range(0, 63));
         mem_bot[a] = CW'($urandom_range(0, 63));
      end
   endtask

   initial begin
      int t1, t2, t3;
      for (int a = 0; a < COLS*SCAN_ROWS; a++) begin
         mem_top[a] = '0;
         mem_bot[a] = '0;
      end
      repeat (100) begin
         @(negedge clk);
         check("reset pins {OE,LAT,CLK_OUT,fb_rd,ADDR,frame_done}", int'({OE, LAT, CLK_OUT, fb_rd, ADDR, frame_done}), 32);
      end
      @(posedge clk) #1 rst = 1'b1;
      repeat (100) begin
         @(negedge clk);
         check("idle pins {OE,LAT,CLK_OUT,fb_rd,ADDR,frame_done}", int'({OE, LAT, CLK_OUT, fb_rd, ADDR, frame_done}), 32);
      end
      mon_on = 1'b1;
      for (int a = 0; a < COLS*SCAN_ROWS; a++) begin
         mem_top[a] = 6'h3F;
         mem_bot[a] = 6'h00;
      end
      run_frame();
      for (int a = 0; a < COLS*SCAN_ROWS; a++) mem_top[a] = CW'((a % COLS) << (2 * COLOR_BITS));
      run_frame();
      for (int k = 0; k < 4; k++) begin
`ifdef BRIGHTNESS_EN
         set_br(k == 0 ? 127 : k == 1 ? 0 : int'($urandom_range(0, 255)));
`endif
         fill_random();
         run_frame();
      end
      fill_random();
      repeat (3) push_frame();
      @(posedge clk) #1 en = 1'b1;
      wait_done(t1);
      wait_done(t2);
      check("frame period", t2 - t1, frame_cycles());
      repeat (40) @(negedge clk);
      @(posedge clk) #1 en = 1'b0;
      wait_done(t3);
      check("frame period after en drop", t3 - t2, frame_cycles());
      drained();
      mon_on = 1'b0;
      for (int a = 0; a < COLS*SCAN_ROWS; a++) begin
         mem_top[a] = 6'h3F;
         mem_bot[a] = 6'h3F;
      end
      @(posedge clk) #1 en = 1'b1;
      @(posedge clk) #1 en = 1'b0;
      repeat (4) @(negedge clk);
      check("in SHIFT before reset", int'(CLK_OUT || fb_rd || R0), 1);
      #2 rst = 1'b0;
      #1 check("async reset pins", int'({OE, LAT, CLK_OUT, fb_rd, ADDR, frame_done, R0, G0, B0, R1, G1, B1}), 2048);
      @(posedge clk) #1 rst = 1'b1;
      exp_addr_q.delete(); exp_pix_q.delete(); exp_row_q.delete(); exp_on_q.delete();
      mon_on = 1'b1;
      set_br(255);
      fill_random();
      run_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
